// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory dump engine: default widths and FSM state encoding.
package mem_dump_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int DEFAULT_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mem_dump.sv
// Streams a block of words read from a data BRAM debug port out as bytes,
// least significant byte first, over a valid/ready byte channel.
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int WORD_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [WORD_W-1:0] debug_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] WORD_STEP = ONE << 2;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [WORD_W-1:0] word_buf;
    logic [1:0]        idx;
    logic              last_byte;
    logic [7:0]        cur_byte;

    assign last_byte = (state == SEND) && tx_ready && (idx == 2'd3);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count != '0) ? FETCH : FINISH;
                end
            end
            FETCH: begin
                state_next = SEND;
            end
            SEND: begin
                if (last_byte) begin
                    state_next = (remaining > ONE) ? FETCH : FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address wraps naturally at 2^ADDR_W; start is only looked at in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            word_buf  <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (word_count != '0)) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                    end
                end
                FETCH: begin
                    word_buf <= debug_data;
                    idx      <= '0;
                end
                SEND: begin
                    if (tx_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            addr      <= addr + WORD_STEP;
                            remaining <= remaining - ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        cur_byte = word_buf[7:0];
        case (idx)
            2'd0: cur_byte = word_buf[7:0];
            2'd1: cur_byte = word_buf[15:8];
            2'd2: cur_byte = word_buf[23:16];
            2'd3: cur_byte = word_buf[31:24];
            default: cur_byte = word_buf[7:0];
        endcase
    end

    assign debug_addr = addr;
    assign tx_valid   = (state == SEND);
    assign tx_data    = (state == SEND) ? cur_byte : 8'h00;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);

endmodule

// File: tb/tb_mem_dump.sv
// Randomized scoreboard bench for mem_dump: expected bytes are derived from a
// word-array memory model and checked by an independent monitor process.
module tb_mem_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  word_count;
    logic [9:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] mem [256];
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          cycle_no = 0;
    int          bytes_seen = 0;
    int          done_count = 0;
    int          ready_mode = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;

    mem_dump dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .debug_addr(debug_addr), .debug_data(debug_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    assign debug_data = mem[debug_addr[9:2]];

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_no++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives tx_ready: held high, alternating, or random per dump.
    initial begin
        tx_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1;
                1: tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted byte, and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", {31'd0, tx_valid}, 32'd1);
                checkOutput("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid) checkOutput("valid_busy", {31'd0, busy}, 32'd1);
            if (tx_valid && tx_ready) begin
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) done_count++;
        end
    end

    function automatic void pushExpected(input logic [9:0] base, input logic [9:0] cnt);
        int a;
        logic [31:0] w;
        for (int k = 0; k < int'(cnt); k++) begin
            a = (int'(base) + 4 * k) % 1024;
            w = mem[a / 4];
            for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        end
    endfunction

    // One complete dump: queue expectations, pulse start, wait for done and check it.
    task automatic applyStimulus(input logic [9:0] base, input logic [9:0] cnt, input int mode, input bit spam);
        int start_cycle;
        int done_before;
        bit seen;
        ready_mode = mode;
        if (mode == 0) tx_ready = 1;
        pushExpected(base, cnt);
        done_before = done_count;
        @(negedge clk);
        start = 1; base_addr = base; word_count = cnt;
        @(posedge clk);
        #1;
        start_cycle = cycle_no;
        start = 0;
        seen = 0;
        for (int i = 0; i < 40 * int'(cnt) + 20; i++) begin
            @(negedge clk);
            if (spam && (i == 3 || i == 9)) begin
                start = 1; base_addr = 10'h100; word_count = 10'd5;
            end else begin
                start = 0;
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        start = 0;
        checkOutput("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput("done_busy", {31'd0, busy}, 32'd1);
            checkOutput("done_queue_empty", exp_q.size(), 32'd0);
            if (mode == 0) checkOutput("done_latency", cycle_no - start_cycle, 5 * int'(cnt));
            @(negedge clk);
            checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("done_pulses", done_count - done_before, 32'd1);
        end
        exp_q.delete();
    endtask

    initial begin
        int waited;
        int seen_before;
        int done_before;
        rst = 1; start = 0; base_addr = '0; word_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_debug_addr", {22'd0, debug_addr}, 32'd0);
        rst = 0;
        @(negedge clk);

        mem[0] = 32'h0000_0001; mem[1] = 32'hFFFF_FFFF;
        applyStimulus(10'h000, 10'd2, 0, 0);
        applyStimulus(10'h000, 10'd2, 1, 0);
        applyStimulus(10'h000, 10'd0, 0, 0);
        mem[255] = 32'hAABB_CCDD; mem[0] = 32'h1122_3344;
        applyStimulus(10'h3FC, 10'd2, 0, 0);
        applyStimulus(10'h010, 10'd3, 2, 1);

        // Abort a dump with reset after its second byte has been accepted.
        ready_mode = 0; tx_ready = 1;
        pushExpected(10'h020, 10'd2);
        done_before = done_count;
        seen_before = bytes_seen;
        @(negedge clk);
        start = 1; base_addr = 10'h020; word_count = 10'd2;
        @(negedge clk);
        start = 0;
        waited = 0;
        while (bytes_seen - seen_before < 2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_bytes_reached", {31'd0, waited < 50}, 32'd1);
        @(posedge clk);
        #1 rst = 1;
        #1;
        checkOutput("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_debug_addr", {22'd0, debug_addr}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", done_count - done_before, 32'd0);
        checkOutput("abort_idle", {31'd0, busy}, 32'd0);
        applyStimulus(10'h020, 10'd2, 0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            applyStimulus(10'($urandom_range(0, 255) << 2), 10'($urandom_range(1, 6)),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
